y86_dmem_responder: RTL

Responder side of the SEQ memory-stage data-memory access: accepts one 8-byte read or write request per handshake, serialises it over a byte-wide internal store one byte per cycle, and returns read data or a write acknowledge with an address-error flag. It replaces the memory stage's combinational 4096-byte array with a clocked, handshaked slave. Byte order is big-endian: the byte at `addr` carries bits 63:56.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/y86_dmem_responder_if.sv | 24 ++
 rtl/dmem_byte_ram.sv | 24 ++
 rtl/y86_dmem_responder.sv | 105 ++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes and the data-memory responder FSM states.
package y86_pkg;

    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/y86_dmem_responder_if.sv
// Request/response handshake between the memory stage (master) and the data-memory responder (slave).
interface y86_dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port byte store: synchronous write, asynchronous read. Contents are not reset.
module dmem_byte_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [DEPTH];

    // Byte write on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/y86_dmem_responder.sv
// Data-memory responder: one 8-byte big-endian access per handshake, moved one byte per cycle.
module y86_dmem_responder
    import y86_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    y86_dmem_responder_if.slave  bus
);

    dmem_state_t   r_state;
    logic [2:0]    r_cnt;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rdata;
    logic          r_err;
    logic          r_resp_valid;

    logic          w_oob;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [7:0]    w_ram_rdata;

    // An access is in range only when all eight bytes lie inside the store
    assign w_oob = (|bus.req_addr[63:AW]) || (bus.req_addr[AW-1:0] > AW'(DEPTH - 8));

    // Reset gates the write so an abort never commits the byte of that cycle
    assign w_ram_we   = (r_state == S_XFER) && r_write && !reset;
    assign w_ram_addr = r_addr + AW'(r_cnt);

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata[63:56]),
        .rdata (w_ram_rdata)
    );

    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // Control FSM; write data shifts out MSB-first, read data shifts in MSB-first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 64'd0;
            r_rdata      <= 64'd0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr[AW-1:0];
                        r_wdata <= bus.req_wdata;
                        r_rdata <= 64'd0;
                        r_cnt   <= 3'd0;
                        if (w_oob) begin
                            r_err        <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (r_write) begin
                        r_wdata <= {r_wdata[55:0], 8'h00};
                    end else begin
                        r_rdata <= {r_rdata[55:0], w_ram_rdata};
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
